// File: rtl/beta_seq_controller.sv
// Multi-cycle sequencer for the Beta CPU: walks fetch/decode/memory/execute phases,
// handles memory handshake timeouts, halt, interrupt acceptance and a sticky fault.
module beta_seq_controller #(
    parameter int unsigned OPC_W   = 6,
    parameter int unsigned TIMEOUT = 16,
    parameter int unsigned CNT_W   = 5,
    parameter int unsigned IRQ_EN  = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [OPC_W-1:0] opcode,
    input  logic             mem_ack,
    input  logic             irq,
    input  logic             halt,
    output logic [2:0]       state,
    output logic             mem_req,
    output logic             mem_we,
    output logic             ir_load,
    output logic             pc_inc,
    output logic             rf_we,
    output logic             retire,
    output logic             irq_take,
    output logic             fault
);

    localparam logic [2:0] S_FETCH     = 3'd0;
    localparam logic [2:0] S_PC_UPDATE = 3'd1;
    localparam logic [2:0] S_DECODE    = 3'd2;
    localparam logic [2:0] S_MEM_READ  = 3'd3;
    localparam logic [2:0] S_EXECUTE   = 3'd4;
    localparam logic [2:0] S_MEM_WRITE = 3'd5;
    localparam logic [2:0] S_HALTED    = 3'd6;
    localparam logic [2:0] S_FAULT     = 3'd7;

    localparam logic [1:0] C_LOAD  = 2'd0;
    localparam logic [1:0] C_STORE = 2'd1;
    localparam logic [1:0] C_EXEC  = 2'd2;
    localparam logic [1:0] C_ILL   = 2'd3;

    localparam logic              TO_EN    = (TIMEOUT != 0);
    localparam logic              IRQ_ON   = (IRQ_EN != 0);
    localparam int unsigned       TO_LAST  = (TIMEOUT == 0) ? 0 : TIMEOUT - 1;
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(TO_LAST);
    localparam logic [CNT_W-1:0]  CNT_MAX  = '1;

    logic [2:0]       state_q, state_d;
    logic [1:0]       cls_q, cls_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [5:0]       op6;
    logic [1:0]       op_cls;
    logic             req_c, ack_c, timeout_c, retire_c;

    // Opcode class decode on the low six bits
    always_comb begin
        op6    = opcode[5:0];
        op_cls = C_ILL;
        if (op6 == 6'h18 || op6 == 6'h1F)
            op_cls = C_LOAD;
        else if (op6 == 6'h19)
            op_cls = C_STORE;
        else if (op6 == 6'h1B || op6 == 6'h1C || op6 == 6'h1D || op6[5])
            op_cls = C_EXEC;
    end

    assign req_c     = (state_q == S_FETCH) || (state_q == S_MEM_READ) || (state_q == S_MEM_WRITE);
    assign ack_c     = req_c && mem_ack;
    assign timeout_c = TO_EN && req_c && !mem_ack && (cnt_q == CNT_LAST);
    assign retire_c  = ((state_q == S_EXECUTE) && (cls_q != C_STORE)) ||
                       ((state_q == S_MEM_WRITE) && mem_ack);

    always_comb begin
        state_d = state_q;
        cls_d   = cls_q;
        case (state_q)
            S_FETCH: begin
                if (mem_ack)        state_d = S_PC_UPDATE;
                else if (timeout_c) state_d = S_FAULT;
            end
            S_PC_UPDATE: state_d = S_DECODE;
            S_DECODE: begin
                cls_d = op_cls;
                case (op_cls)
                    C_LOAD:          state_d = S_MEM_READ;
                    C_STORE, C_EXEC: state_d = S_EXECUTE;
                    default:         state_d = S_FAULT;
                endcase
            end
            S_MEM_READ: begin
                if (mem_ack)        state_d = S_EXECUTE;
                else if (timeout_c) state_d = S_FAULT;
            end
            S_EXECUTE: begin
                if (cls_q == C_STORE) state_d = S_MEM_WRITE;
                else                  state_d = halt ? S_HALTED : S_FETCH;
            end
            S_MEM_WRITE: begin
                if (mem_ack)        state_d = halt ? S_HALTED : S_FETCH;
                else if (timeout_c) state_d = S_FAULT;
            end
            S_HALTED: begin
                if (!halt) state_d = S_FETCH;
            end
            default: state_d = S_FAULT;
        endcase

        // Wait counter restarts on every state change (covers memory-state entry) and on ack
        cnt_d = cnt_q;
        if (state_d != state_q || ack_c)
            cnt_d = '0;
        else if (req_c && cnt_q != CNT_MAX)
            cnt_d = cnt_q + CNT_W'(1);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_FETCH;
            cls_q   <= C_LOAD;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cls_q   <= cls_d;
            cnt_q   <= cnt_d;
        end
    end

    // Strobes decode the state register; reset forces all of them low immediately
    assign state    = reset ? S_FETCH : state_q;
    assign mem_req  = !reset && req_c;
    assign mem_we   = !reset && (state_q == S_MEM_WRITE);
    assign ir_load  = !reset && (state_q == S_FETCH) && mem_ack;
    assign pc_inc   = !reset && (state_q == S_PC_UPDATE);
    assign rf_we    = !reset && (state_q == S_EXECUTE) && (cls_q != C_STORE);
    assign retire   = !reset && retire_c;
    assign irq_take = !reset && retire_c && IRQ_ON && irq && !halt;
    assign fault    = !reset && (state_q == S_FAULT);

endmodule
